// File: rtl/key_loader.sv
// Serial key loader: shifts a key into a shadow register and commits it atomically.
// Optional even-parity check on the stream is enabled by KEY_LOADER_PARITY_EN.
module key_loader #(
  parameter int KEY_WIDTH = 3,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load_start,
  input  logic                 key_bit_in,
  input  logic                 key_bit_valid,
  output logic                 key_bit_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY,
    S_COMMIT,
    S_ARMED
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [KEY_WIDTH-1:0] r_shadow;
  logic [KEY_WIDTH-1:0] w_shadow_nxt;
  logic [KEY_WIDTH-1:0] r_key;
  logic [KEY_WIDTH-1:0] w_key_nxt;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 w_xfer;
  logic                 w_last;
`ifdef KEY_LOADER_PARITY_EN
  logic                 r_err;
  logic                 w_err_nxt;
`endif

  assign key_bit_ready = (r_state == S_SHIFT) || (r_state == S_PARITY);
  assign busy          = key_bit_ready || (r_state == S_COMMIT);
  assign w_xfer        = key_bit_valid & key_bit_ready;
  assign w_last        = (r_count == CNT_W'(KEY_WIDTH - 1));
  assign key_out       = r_key;
  assign key_valid     = r_valid;
`ifdef KEY_LOADER_PARITY_EN
  assign error         = r_err;
`else
  assign error         = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_key_nxt    = r_key;
    w_count_nxt  = r_count;
    w_valid_nxt  = r_valid;
`ifdef KEY_LOADER_PARITY_EN
    w_err_nxt    = r_err;
`endif
    if (clear) begin
      w_state_nxt  = S_IDLE;
      w_shadow_nxt = '0;
      w_key_nxt    = '0;
      w_count_nxt  = '0;
      w_valid_nxt  = 1'b0;
`ifdef KEY_LOADER_PARITY_EN
      w_err_nxt    = 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_ARMED: begin
          if (load_start) begin
            // key_out keeps the old key; only the valid flag drops
            w_state_nxt  = S_SHIFT;
            w_shadow_nxt = '0;
            w_count_nxt  = '0;
            w_valid_nxt  = 1'b0;
`ifdef KEY_LOADER_PARITY_EN
            w_err_nxt    = 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          if (w_xfer) begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
              if (r_count == CNT_W'(i)) w_shadow_nxt[i] = key_bit_in;
            end
            w_count_nxt = r_count + CNT_W'(1);
            if (w_last) begin
`ifdef KEY_LOADER_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_COMMIT;
`endif
            end
          end
        end
        S_PARITY: begin
`ifdef KEY_LOADER_PARITY_EN
          if (w_xfer) begin
            if ((^r_shadow) ^ key_bit_in) begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end else begin
              w_state_nxt = S_COMMIT;
            end
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end
        S_COMMIT: begin
          w_key_nxt   = r_shadow;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_ARMED;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_key    <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_key    <= w_key_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

`ifdef KEY_LOADER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_err_nxt;
  end
`endif

endmodule
